// File: rtl/bsg_manycore_drlp_pkg.sv
// Shared DRLP definitions: array geometry and the weight-lane state encoding.
package bsg_manycore_drlp_pkg;

    localparam int drlp_num_pe_lp      = 16;
    localparam int drlp_wgt_per_pe_lp  = 18;
    localparam int drlp_dw_wgt_lp      = 9;
    localparam int drlp_data_width_lp  = 32;
    localparam int drlp_cnt_width_lp   = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        BIAS   = 2'd2
    } lane_state_e;

endpackage

// File: rtl/bsg_manycore_drlp_wgt_lane.sv
// One weight lane: shadow buffer filled by the master, active buffer streamed
// word by word to the PE, followed by a single bias beat.
module bsg_manycore_drlp_wgt_lane
    import bsg_manycore_drlp_pkg::*;
#(
    parameter int wgt_per_pe_p = drlp_wgt_per_pe_lp,
    parameter int dw_wgt_p     = drlp_dw_wgt_lp,
    parameter int data_width_p = drlp_data_width_lp
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 data_v_i,
    input  logic [wgt_per_pe_p*data_width_p-1:0] wgt_i,
    input  logic [data_width_p-1:0]              bias_i,
    input  logic                                 sld_accept_i,
    input  logic                                 mode_i,
    input  logic                                 yumi_i,
    output logic [data_width_p-1:0]              data_o,
    output logic                                 v_o,
    output logic                                 last_o,
    output logic                                 shadow_full_o,
    output logic                                 idle_o,
    output logic                                 finishing_o,
    output logic                                 drop_err_o,
    output logic                                 yumi_err_o
);

    logic [data_width_p-1:0] wgt_word [wgt_per_pe_p];
    logic [data_width_p-1:0] shadow_wgt_reg [wgt_per_pe_p];
    logic [data_width_p-1:0] active_wgt_reg [wgt_per_pe_p];
    logic [data_width_p-1:0] shadow_bias_reg;
    logic [data_width_p-1:0] active_bias_reg;
    logic                    shadow_full_reg;
    lane_state_e             state_reg, state_next;
    logic [drlp_cnt_width_lp-1:0] cnt_reg, cnt_next;
    logic [drlp_cnt_width_lp-1:0] last_idx;
    logic                    capture;

    genvar gi;
    generate
        for (gi = 0; gi < wgt_per_pe_p; gi++) begin : g_word
            assign wgt_word[gi] = wgt_i[gi*data_width_p +: data_width_p];
        end
    endgenerate

    // A full shadow may still accept new data when it is emptied on the same edge.
    assign capture    = data_v_i & (~shadow_full_reg | sld_accept_i);
    assign drop_err_o = data_v_i & shadow_full_reg & ~sld_accept_i;

    always_ff @(posedge clk_i) begin
        if (capture) begin
            for (int k = 0; k < wgt_per_pe_p; k++) shadow_wgt_reg[k] <= wgt_word[k];
            shadow_bias_reg <= bias_i;
        end
        if (sld_accept_i) begin
            for (int k = 0; k < wgt_per_pe_p; k++) active_wgt_reg[k] <= shadow_wgt_reg[k];
            active_bias_reg <= shadow_bias_reg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            shadow_full_reg <= 1'b0;
            state_reg       <= IDLE;
            cnt_reg         <= '0;
        end else begin
            if (capture)
                shadow_full_reg <= 1'b1;
            else if (sld_accept_i)
                shadow_full_reg <= 1'b0;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign last_idx = mode_i ? drlp_cnt_width_lp'(dw_wgt_p - 1)
                             : drlp_cnt_width_lp'(wgt_per_pe_p - 1);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (sld_accept_i) begin
                    state_next = STREAM;
                    cnt_next   = '0;
                end
            end
            STREAM: begin
                if (yumi_i) begin
                    if (cnt_reg == last_idx) begin
                        state_next = BIAS;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            BIAS: begin
                if (yumi_i) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        data_o = '0;
        if (state_reg == STREAM && cnt_reg < drlp_cnt_width_lp'(wgt_per_pe_p))
            data_o = active_wgt_reg[cnt_reg];
        else if (state_reg == BIAS)
            data_o = active_bias_reg;
    end

    assign v_o           = (state_reg != IDLE);
    assign last_o        = (state_reg == BIAS);
    assign shadow_full_o = shadow_full_reg;
    assign idle_o        = (state_reg == IDLE);
    assign finishing_o   = (state_reg == BIAS) & yumi_i;
    assign yumi_err_o    = yumi_i & ~v_o;

endmodule

// File: rtl/bsg_manycore_drlp_wgt_dist.sv
// DRLP weight distributor: per-lane double-buffered weight/bias capture and
// serial streaming to the PEs, with batch-level ready/done handshakes.
module bsg_manycore_drlp_wgt_dist
    import bsg_manycore_drlp_pkg::*;
#(
    parameter int num_pe_p     = drlp_num_pe_lp,
    parameter int wgt_per_pe_p = drlp_wgt_per_pe_lp,
    parameter int dw_wgt_p     = drlp_dw_wgt_lp,
    parameter int data_width_p = drlp_data_width_lp
) (
    input  logic                                          clk_i,
    input  logic                                          reset_n_i,
    input  logic [num_pe_p-1:0]                           pe_data_v_i,
    input  logic [data_width_p*num_pe_p*wgt_per_pe_p-1:0] all_wgt_i,
    input  logic [data_width_p*num_pe_p-1:0]              all_bias_i,
    input  logic                                          sld_i,
    input  logic                                          dw_wgt_start_i,
    output logic [data_width_p*num_pe_p-1:0]              pe_wgt_data_o,
    output logic [num_pe_p-1:0]                           pe_wgt_v_o,
    output logic [num_pe_p-1:0]                           pe_wgt_last_o,
    input  logic [num_pe_p-1:0]                           pe_wgt_yumi_i,
    output logic                                          all_pe_ready_o,
    output logic                                          all_slave_done_o,
    output logic                                          err_o
);

    localparam int lane_w_lp = wgt_per_pe_p * data_width_p;

    logic [num_pe_p-1:0] shadow_full;
    logic [num_pe_p-1:0] idle;
    logic [num_pe_p-1:0] finishing;
    logic [num_pe_p-1:0] drop_err;
    logic [num_pe_p-1:0] yumi_err;
    logic                sld_accept;
    logic                mode_reg;
    logic                batch_reg;
    logic                done_reg;
    logic                err_reg;
    logic                err_next;

    assign sld_accept = sld_i & (&shadow_full) & (&idle);

    genvar gi;
    generate
        for (gi = 0; gi < num_pe_p; gi++) begin : g_lane
            bsg_manycore_drlp_wgt_lane #(
                .wgt_per_pe_p (wgt_per_pe_p),
                .dw_wgt_p     (dw_wgt_p),
                .data_width_p (data_width_p)
            ) lane (
                .clk_i         (clk_i),
                .reset_n_i     (reset_n_i),
                .data_v_i      (pe_data_v_i[gi]),
                .wgt_i         (all_wgt_i[gi*lane_w_lp +: lane_w_lp]),
                .bias_i        (all_bias_i[gi*data_width_p +: data_width_p]),
                .sld_accept_i  (sld_accept),
                .mode_i        (mode_reg),
                .yumi_i        (pe_wgt_yumi_i[gi]),
                .data_o        (pe_wgt_data_o[gi*data_width_p +: data_width_p]),
                .v_o           (pe_wgt_v_o[gi]),
                .last_o        (pe_wgt_last_o[gi]),
                .shadow_full_o (shadow_full[gi]),
                .idle_o        (idle[gi]),
                .finishing_o   (finishing[gi]),
                .drop_err_o    (drop_err[gi]),
                .yumi_err_o    (yumi_err[gi])
            );
        end
    endgenerate

    assign err_next = err_reg | (sld_i & ~sld_accept) | (|drop_err) | (|yumi_err);

    // Done is raised on the edge where the last bias beat is consumed, so it
    // is visible in the first cycle that every lane reads back as idle.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            mode_reg  <= 1'b0;
            batch_reg <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            err_reg <= err_next;
            if (sld_accept) begin
                mode_reg  <= dw_wgt_start_i;
                batch_reg <= 1'b1;
                done_reg  <= 1'b0;
            end else if (batch_reg && (&(idle | finishing))) begin
                batch_reg <= 1'b0;
                done_reg  <= 1'b1;
            end
        end
    end

    assign all_pe_ready_o   = ~|shadow_full;
    assign all_slave_done_o = done_reg;
    assign err_o            = err_reg;

endmodule

// File: tb/tb_bsg_manycore_drlp_wgt_dist.sv
// Directed bench for the DRLP weight distributor.
module tb_bsg_manycore_drlp_wgt_dist;

    localparam int NPE = 16;
    localparam int WPE = 18;
    localparam int DW  = 32;

    logic                   clk;
    logic                   reset_n;
    logic [NPE-1:0]         pe_data_v;
    logic [DW*NPE*WPE-1:0]  all_wgt;
    logic [DW*NPE-1:0]      all_bias;
    logic                   sld;
    logic                   dw_start;
    logic [DW*NPE-1:0]      pe_wgt_data;
    logic [NPE-1:0]         pe_wgt_v;
    logic [NPE-1:0]         pe_wgt_last;
    logic [NPE-1:0]         pe_wgt_yumi;
    logic                   all_pe_ready;
    logic                   all_slave_done;
    logic                   err;

    int vectors;
    int miscompares;

    bsg_manycore_drlp_wgt_dist dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .pe_data_v_i      (pe_data_v),
        .all_wgt_i        (all_wgt),
        .all_bias_i       (all_bias),
        .sld_i            (sld),
        .dw_wgt_start_i   (dw_start),
        .pe_wgt_data_o    (pe_wgt_data),
        .pe_wgt_v_o       (pe_wgt_v),
        .pe_wgt_last_o    (pe_wgt_last),
        .pe_wgt_yumi_i    (pe_wgt_yumi),
        .all_pe_ready_o   (all_pe_ready),
        .all_slave_done_o (all_slave_done),
        .err_o            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    function automatic logic [31:0] exp_wgt(input int tag, input int lane, input int k);
        exp_wgt = {tag[7:0], lane[7:0], k[15:0]};
    endfunction

    function automatic logic [31:0] exp_bias(input int tag, input int lane);
        exp_bias = {8'hBB, 8'h00, tag[7:0], lane[7:0]};
    endfunction

    function automatic logic [31:0] lane_data(input int lane);
        lane_data = pe_wgt_data[lane*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int tag);
        for (int i = 0; i < NPE; i++) begin
            for (int k = 0; k < WPE; k++)
                all_wgt[(i*WPE+k)*DW +: DW] = exp_wgt(tag, i, k);
            all_bias[i*DW +: DW] = exp_bias(tag, i);
        end
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        pe_data_v   = '0;
        sld         = 1'b0;
        dw_start    = 1'b0;
        pe_wgt_yumi = '0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic fill(input int tag, input logic [NPE-1:0] mask);
        set_data(tag);
        pe_data_v = mask;
        tick();
        pe_data_v = '0;
    endtask

    task automatic pulse_sld(input logic dw);
        sld      = 1'b1;
        dw_start = dw;
        tick();
        sld      = 1'b0;
        dw_start = 1'b0;
    endtask

    task automatic drain(input int beats);
        pe_wgt_yumi = '1;
        repeat (beats) tick();
        pe_wgt_yumi = '0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (pe_wgt_v !== '0 || pe_wgt_last !== '0 || pe_wgt_data !== '0) begin
            $display("FAIL reset_outputs: v=%h last=%h, required 0", pe_wgt_v, pe_wgt_last);
            miscompares++;
        end
        vectors++;
        if (all_pe_ready !== 1'b1 || all_slave_done !== 1'b0 || err !== 1'b0) begin
            $display("FAIL reset_flags: ready=%b done=%b err=%b, required 1 0 0",
                     all_pe_ready, all_slave_done, err);
            miscompares++;
        end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        do_reset();
        fill(0, '1);
        vectors++;
        if (all_pe_ready !== 1'b0) begin
            $display("FAIL stream_ready_after_fill: got %b, required 0", all_pe_ready);
            miscompares++;
        end
        pulse_sld(1'b0);
        vectors++;
        if (pe_wgt_v !== '1 || all_pe_ready !== 1'b1) begin
            $display("FAIL stream_start: v=%h ready=%b, required ffff 1", pe_wgt_v, all_pe_ready);
            miscompares++;
        end
        pe_wgt_yumi = '1;
        for (int b = 0; b < 19; b++) begin
            logic [31:0] exp_d;
            exp_d = (b < 18) ? exp_wgt(0, 5, b) : exp_bias(0, 5);
            vectors++;
            if (pe_wgt_v[5] !== 1'b1 || lane_data(5) !== exp_d ||
                pe_wgt_last[5] !== (b == 18) || all_slave_done !== 1'b0) begin
                $display("FAIL stream_beat%0d: v=%b data=%h last=%b done=%b, required 1 %h %b 0",
                         b, pe_wgt_v[5], lane_data(5), pe_wgt_last[5], all_slave_done,
                         exp_d, (b == 18));
                miscompares++;
            end
            tick();
        end
        pe_wgt_yumi = '0;
        vectors++;
        if (all_slave_done !== 1'b1 || pe_wgt_v !== '0 || err !== 1'b0) begin
            $display("FAIL stream_done: done=%b v=%h err=%b, required 1 0000 0",
                     all_slave_done, pe_wgt_v, err);
            miscompares++;
        end
        $display("test_stream done");
    endtask

    task automatic test_dw();
        fill(1, '1);
        pulse_sld(1'b1);
        pe_wgt_yumi = '1;
        for (int b = 0; b < 10; b++) begin
            logic [31:0] exp_d;
            exp_d = (b < 9) ? exp_wgt(1, 5, b) : exp_bias(1, 5);
            vectors++;
            if (lane_data(5) !== exp_d || pe_wgt_last[5] !== (b == 9) ||
                pe_wgt_last[12] !== (b == 9) || pe_wgt_v !== '1) begin
                $display("FAIL dw_beat%0d: data=%h last5=%b last12=%b v=%h, required %h %b",
                         b, lane_data(5), pe_wgt_last[5], pe_wgt_last[12], pe_wgt_v,
                         exp_d, (b == 9));
                miscompares++;
            end
            tick();
        end
        pe_wgt_yumi = '0;
        vectors++;
        if (all_slave_done !== 1'b1 || pe_wgt_v !== '0) begin
            $display("FAIL dw_done: done=%b v=%h, required 1 0000", all_slave_done, pe_wgt_v);
            miscompares++;
        end
        $display("test_dw done");
    endtask

    task automatic test_backpressure();
        int idx;
        int cyc;
        logic y3;
        fill(2, '1);
        pulse_sld(1'b0);
        idx = 0;
        cyc = 0;
        while (idx < 19 && cyc < 300) begin
            logic [31:0] exp_d;
            if (cyc == 19) begin
                vectors++;
                if (pe_wgt_v[0] !== 1'b0 || pe_wgt_v[15] !== 1'b0 || all_slave_done !== 1'b0) begin
                    $display("FAIL bp_others: v0=%b v15=%b done=%b, required 0 0 0",
                             pe_wgt_v[0], pe_wgt_v[15], all_slave_done);
                    miscompares++;
                end
            end
            exp_d = (idx < 18) ? exp_wgt(2, 3, idx) : exp_bias(2, 3);
            vectors++;
            if (pe_wgt_v[3] !== 1'b1 || lane_data(3) !== exp_d || pe_wgt_last[3] !== (idx == 18)) begin
                $display("FAIL bp_beat%0d: v=%b data=%h last=%b, required 1 %h %b",
                         idx, pe_wgt_v[3], lane_data(3), pe_wgt_last[3], exp_d, (idx == 18));
                miscompares++;
            end
            y3 = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            pe_wgt_yumi = (cyc < 19) ? 16'hFFF7 : 16'h0000;
            pe_wgt_yumi[3] = y3;
            tick();
            if (y3) idx++;
            cyc++;
        end
        pe_wgt_yumi = '0;
        vectors++;
        if (idx != 19) begin
            $display("FAIL bp_timeout: beats=%0d, required 19", idx);
            miscompares++;
        end
        vectors++;
        if (all_slave_done !== 1'b1 || pe_wgt_v !== '0 || err !== 1'b0) begin
            $display("FAIL bp_done: done=%b v=%h err=%b, required 1 0000 0",
                     all_slave_done, pe_wgt_v, err);
            miscompares++;
        end
        $display("test_backpressure done");
    endtask

    task automatic test_errors();
        do_reset();
        fill(3, 16'hFF7F);
        pulse_sld(1'b0);
        vectors++;
        if (pe_wgt_v !== '0 || err !== 1'b1 || all_pe_ready !== 1'b0 || all_slave_done !== 1'b0) begin
            $display("FAIL err_sld_empty: v=%h err=%b ready=%b done=%b, required 0000 1 0 0",
                     pe_wgt_v, err, all_pe_ready, all_slave_done);
            miscompares++;
        end
        do_reset();
        fill(3, 16'h0080);
        vectors++;
        if (err !== 1'b0) begin
            $display("FAIL err_single_fill: got %b, required 0", err);
            miscompares++;
        end
        fill(4, 16'h0080);
        vectors++;
        if (err !== 1'b1) begin
            $display("FAIL err_double_fill: got %b, required 1", err);
            miscompares++;
        end
        do_reset();
        pe_wgt_yumi = 16'h0001;
        tick();
        pe_wgt_yumi = '0;
        vectors++;
        if (err !== 1'b1) begin
            $display("FAIL err_yumi_idle: got %b, required 1", err);
            miscompares++;
        end
        $display("test_errors done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        fill(4, '1);
        pulse_sld(1'b0);
        drain(19);
        fill(5, '1);
        vectors++;
        if (all_slave_done !== 1'b1 || all_pe_ready !== 1'b0) begin
            $display("FAIL b2b_a_done: done=%b ready=%b, required 1 0", all_slave_done, all_pe_ready);
            miscompares++;
        end
        set_data(6);
        pe_data_v = '1;
        sld = 1'b1;
        tick();
        pe_data_v = '0;
        sld = 1'b0;
        vectors++;
        if (all_slave_done !== 1'b0 || pe_wgt_v !== '1 || lane_data(5) !== exp_wgt(5, 5, 0) ||
            all_pe_ready !== 1'b0 || err !== 1'b0) begin
            $display("FAIL b2b_b_start: done=%b v=%h data=%h ready=%b err=%b, required 0 ffff %h 0 0",
                     all_slave_done, pe_wgt_v, lane_data(5), all_pe_ready, err, exp_wgt(5, 5, 0));
            miscompares++;
        end
        drain(18);
        vectors++;
        if (lane_data(5) !== exp_bias(5, 5) || pe_wgt_last[5] !== 1'b1) begin
            $display("FAIL b2b_b_bias: data=%h last=%b, required %h 1",
                     lane_data(5), pe_wgt_last[5], exp_bias(5, 5));
            miscompares++;
        end
        drain(1);
        vectors++;
        if (all_slave_done !== 1'b1 || all_pe_ready !== 1'b0) begin
            $display("FAIL b2b_b_done: done=%b ready=%b, required 1 0", all_slave_done, all_pe_ready);
            miscompares++;
        end
        pulse_sld(1'b0);
        vectors++;
        if (lane_data(5) !== exp_wgt(6, 5, 0) || all_pe_ready !== 1'b1 || all_slave_done !== 1'b0) begin
            $display("FAIL b2b_c_start: data=%h ready=%b done=%b, required %h 1 0",
                     lane_data(5), all_pe_ready, all_slave_done, exp_wgt(6, 5, 0));
            miscompares++;
        end
        drain(19);
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill(7, '1);
        pulse_sld(1'b0);
        drain(7);
        vectors++;
        if (lane_data(5) !== exp_wgt(7, 5, 7) || pe_wgt_v !== '1) begin
            $display("FAIL mid_beat7: data=%h v=%h, required %h ffff",
                     lane_data(5), pe_wgt_v, exp_wgt(7, 5, 7));
            miscompares++;
        end
        reset_n = 1'b0;
        tick();
        vectors++;
        if (pe_wgt_v !== '0 || pe_wgt_last !== '0 || pe_wgt_data !== '0 ||
            all_pe_ready !== 1'b1 || all_slave_done !== 1'b0 || err !== 1'b0) begin
            $display("FAIL mid_reset: v=%h last=%h ready=%b done=%b err=%b, required 0000 0000 1 0 0",
                     pe_wgt_v, pe_wgt_last, all_pe_ready, all_slave_done, err);
            miscompares++;
        end
        reset_n = 1'b1;
        tick();
        vectors++;
        if (pe_wgt_v !== '0) begin
            $display("FAIL mid_after: v=%h, required 0000", pe_wgt_v);
            miscompares++;
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        pe_data_v   = '0;
        all_wgt     = '0;
        all_bias    = '0;
        sld         = 1'b0;
        dw_start    = 1'b0;
        pe_wgt_yumi = '0;
        tick();
        test_reset();
        test_stream();
        test_dw();
        test_backpressure();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
